// File: rtl/register_rename_file.sv
// Architectural register file with per-register rename tags: answers dispatcher
// operand lookups combinationally and tracks the in-flight producer of each register.
module register_rename_file #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ROB_ADDR_W = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  dispatcher_en_in,
  input  logic [REG_ADDR_W-1:0] dispatcher_rs1_in,
  input  logic [REG_ADDR_W-1:0] dispatcher_rs2_in,
  input  logic [REG_ADDR_W-1:0] dispatcher_rd_in,
  input  logic [ROB_ADDR_W-1:0] dispatcher_rd_robnum_in,
  output logic [XLEN-1:0]       rs1_data_out,
  output logic                  rs1_busy_out,
  output logic [ROB_ADDR_W-1:0] rs1_robnum_out,
  output logic [XLEN-1:0]       rs2_data_out,
  output logic                  rs2_busy_out,
  output logic [ROB_ADDR_W-1:0] rs2_robnum_out,
  input  logic                  rob_commit_en_in,
  input  logic [REG_ADDR_W-1:0] rob_commit_rd_in,
  input  logic [ROB_ADDR_W-1:0] rob_commit_robnum_in,
  input  logic [XLEN-1:0]       rob_commit_data_in,
  input  logic                  rob_flush_in
);

  localparam int unsigned NREGS  = 1 << REG_ADDR_W;
  localparam int unsigned LOOK_W = XLEN + ROB_ADDR_W + 1;

  logic [XLEN-1:0]       regs_q [NREGS];
  logic [XLEN-1:0]       regs_d [NREGS];
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic [ROB_ADDR_W-1:0] tag_q  [NREGS];
  logic [ROB_ADDR_W-1:0] tag_d  [NREGS];

  logic [LOOK_W-1:0] look1;
  logic [LOOK_W-1:0] look2;

  // Operand lookup returning {busy, robnum, data}; a matching commit bypasses the array.
  function automatic logic [LOOK_W-1:0] lookup(input logic [REG_ADDR_W-1:0] idx);
    logic [LOOK_W-1:0] res;
    res = '0;
    if (idx != '0) begin
      if (rob_commit_en_in && (rob_commit_rd_in == idx) && busy_q[idx] &&
          (tag_q[idx] == rob_commit_robnum_in)) begin
        res = {1'b0, ROB_ADDR_W'(0), rob_commit_data_in};
      end else if (busy_q[idx]) begin
        res = {1'b1, tag_q[idx], regs_q[idx]};
      end else begin
        res = {1'b0, ROB_ADDR_W'(0), regs_q[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    look1 = '0;
    look2 = '0;
    if (!rst_in) begin
      look1 = lookup(dispatcher_rs1_in);
      look2 = lookup(dispatcher_rs2_in);
    end
  end

  assign rs1_data_out   = look1[XLEN-1:0];
  assign rs1_robnum_out = look1[XLEN+ROB_ADDR_W-1:XLEN];
  assign rs1_busy_out   = look1[LOOK_W-1];
  assign rs2_data_out   = look2[XLEN-1:0];
  assign rs2_robnum_out = look2[XLEN+ROB_ADDR_W-1:XLEN];
  assign rs2_busy_out   = look2[LOOK_W-1];

  // Next state: commit first, then flush or dispatch overrides the rename tags.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rob_commit_en_in && (rob_commit_rd_in != '0)) begin
      regs_d[rob_commit_rd_in] = rob_commit_data_in;
      if (busy_q[rob_commit_rd_in] && (tag_q[rob_commit_rd_in] == rob_commit_robnum_in)) begin
        busy_d[rob_commit_rd_in] = 1'b0;
        tag_d[rob_commit_rd_in]  = '0;
      end
    end
    if (rob_flush_in) begin
      busy_d = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
        tag_d[i] = '0;
      end
    end else if (dispatcher_en_in && (dispatcher_rd_in != '0)) begin
      busy_d[dispatcher_rd_in] = 1'b1;
      tag_d[dispatcher_rd_in]  = dispatcher_rd_robnum_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      busy_q <= busy_d;
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= regs_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

endmodule
